// File: rtl/max_pool2d_2x2_stride2_pkg.sv
// pool_pkg: shared constants and helpers for the 2x2/stride-2 FP32 max-pool stage.
//   FP_SIGN_BIT / FP_MAG_MSB   : IEEE-754 single field positions
//   IMG_WIDTH_DEF/IMG_HEIGHT_DEF: default input frame geometry
//   OUT_W / OUT_H              : pooled frame geometry at the defaults
//   cnt_w()                    : counter width for a 0..n-1 counter
package pool_pkg;

    localparam int unsigned FP_SIGN_BIT    = 31;
    localparam int unsigned FP_MAG_MSB     = 30;

    localparam int unsigned IMG_WIDTH_DEF  = 218;
    localparam int unsigned IMG_HEIGHT_DEF = 218;
    localparam int unsigned OUT_W          = IMG_WIDTH_DEF / 2;
    localparam int unsigned OUT_H          = IMG_HEIGHT_DEF / 2;

    function automatic int unsigned cnt_w(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/max_pool2d_2x2_stride2_fp32_max.sv
// fp32_max: combinational max of two sign-magnitude FP32 values.
//   a, b : operands (a is returned on ties, including +0 vs -0)
//   y    : the larger operand
// NaN/Inf are never presented, so no special encodings are handled.
module fp32_max
    import pool_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] y
);

    logic                  sa, sb;
    logic [FP_MAG_MSB:0]   ma, mb;

    assign sa = a[FP_SIGN_BIT];
    assign sb = b[FP_SIGN_BIT];
    assign ma = a[FP_MAG_MSB:0];
    assign mb = b[FP_MAG_MSB:0];

    always_comb begin
        y = a;
        if (ma == '0 && mb == '0) begin
            y = a;                          // +0 and -0 compare equal
        end else if (sa != sb) begin
            y = sa ? b : a;                 // positive operand wins
        end else if (!sa) begin
            y = (mb > ma) ? b : a;          // both positive: larger magnitude
        end else begin
            y = (mb < ma) ? b : a;          // both negative: smaller magnitude
        end
    end

endmodule

// File: rtl/max_pool2d_2x2_stride2.sv
// max_pool2d_2x2_stride2: 2x2 / stride-2 max pooling over CHANNEL_OUT packed FP32 maps.
//   clk, rst   : clock, synchronous active-high reset
//   Data_In    : packed input samples, channel k at [DATA_WIDHT*(k+1)-1 : DATA_WIDHT*k]
//   Valid_In   : input qualifier (gaps allowed, no backpressure)
//   Data_Out   : packed pooled maxima, held between pulses
//   Valid_Out  : one-cycle pulse per pooled word
//   Frame_Done : (only with `define MAXPOOL_FRAME_DONE_EN) pulses with the last
//                pooled word of each frame
// Even columns are held, odd columns form a horizontal pair max; even rows park
// the pair in a line buffer, odd rows combine it with the stored pair.
module max_pool2d_2x2_stride2
    import pool_pkg::*;
#(
    parameter int unsigned DATA_WIDHT  = 32,
    parameter int unsigned IMG_WIDTH   = IMG_WIDTH_DEF,
    parameter int unsigned IMG_HEIGHT  = IMG_HEIGHT_DEF,
    parameter int unsigned CHANNEL_OUT = 8
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [DATA_WIDHT*CHANNEL_OUT-1:0] Data_In,
    input  logic                              Valid_In,
    output logic [DATA_WIDHT*CHANNEL_OUT-1:0] Data_Out,
    output logic                              Valid_Out
`ifdef MAXPOOL_FRAME_DONE_EN
    ,
    output logic                              Frame_Done
`endif
);

    localparam int unsigned BUS_W    = DATA_WIDHT * CHANNEL_OUT;
    localparam int unsigned LB_DEPTH = IMG_WIDTH / 2;
    localparam int unsigned COL_W    = cnt_w(IMG_WIDTH);
    localparam int unsigned ROW_W    = cnt_w(IMG_HEIGHT);
    localparam int unsigned LB_AW    = cnt_w(LB_DEPTH);

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);

    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    logic [BUS_W-1:0] hold;
    logic [BUS_W-1:0] linebuf [LB_DEPTH];
    logic [LB_AW-1:0] lb_idx;
    logic [BUS_W-1:0] lb_rd;
    logic [BUS_W-1:0] pair_max;
    logic [BUS_W-1:0] win_max;

    assign lb_idx = LB_AW'(col >> 1);
    assign lb_rd  = linebuf[lb_idx];

    for (genvar k = 0; k < CHANNEL_OUT; k++) begin : g_ch
        fp32_max u_pair (
            .a (hold[k*DATA_WIDHT +: DATA_WIDHT]),
            .b (Data_In[k*DATA_WIDHT +: DATA_WIDHT]),
            .y (pair_max[k*DATA_WIDHT +: DATA_WIDHT])
        );
        fp32_max u_row (
            .a (pair_max[k*DATA_WIDHT +: DATA_WIDHT]),
            .b (lb_rd[k*DATA_WIDHT +: DATA_WIDHT]),
            .y (win_max[k*DATA_WIDHT +: DATA_WIDHT])
        );
    end

    // Line buffer is deliberately not reset: every odd-row read is preceded
    // by an even-row write of the same entry within the frame.
    always_ff @(posedge clk) begin
        if (!rst && Valid_In && col[0] && !row[0]) begin
            linebuf[lb_idx] <= pair_max;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col       <= '0;
            row       <= '0;
            hold      <= '0;
            Data_Out  <= '0;
            Valid_Out <= 1'b0;
        end else begin
            Valid_Out <= 1'b0;
            if (Valid_In) begin
                if (col == COL_LAST) begin
                    col <= '0;
                    row <= (row == ROW_LAST) ? '0 : row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
                // A trailing even column/row of an odd-sized frame only
                // updates hold/line buffer, so it never yields output.
                if (!col[0]) begin
                    hold <= Data_In;
                end else if (row[0]) begin
                    Data_Out  <= win_max;
                    Valid_Out <= 1'b1;
                end
            end
        end
    end

`ifdef MAXPOOL_FRAME_DONE_EN
    localparam logic [COL_W-1:0] COL_FD = COL_W'(2 * (IMG_WIDTH / 2) - 1);
    localparam logic [ROW_W-1:0] ROW_FD = ROW_W'(2 * (IMG_HEIGHT / 2) - 1);

    always_ff @(posedge clk) begin
        if (rst) begin
            Frame_Done <= 1'b0;
        end else begin
            Frame_Done <= Valid_In && (col == COL_FD) && (row == ROW_FD);
        end
    end
`endif

endmodule
